morse_key_timer: RTL and testbench
==================================

// Module: morse_key_timer
// PURPOSE
//   Front end of the Morse path. Synchronises and debounces the raw key/button
//   (ui_in[0]) and measures press and release durations. Emits one-cycle pulses
//   for dot, dash, end-of-character and end-of-word, which the downstream Morse
//   decoder assembles into characters. It contains no character decoding.
// PARAMETERS
//   CNT_W         24          width of duration/gap/debounce counters (saturating)
//   DEBOUNCE_CYC  50000       consecutive stable cycles needed to accept a level change
//   DOT_MAX_CYC   2000000     press duration < this -> dot
//   DASH_MAX_CYC  10000000    press duration <= this (and >= DOT_MAX_CYC) -> dash; longer -> error
//   CHAR_GAP_CYC  3000000     release duration that ends a character
//   WORD_GAP_CYC  7000000     release duration that ends a word (must be > CHAR_GAP_CYC)
// PORTS
//   clk        in   1  system clock
//   rst_n      in   1  asynchronous active-low reset
//   key_in     in   1  raw key, active high, asynchronous to clk
//   key_level  out  1  debounced key level
//   dot_p      out  1  one-cycle pulse: dot accepted
//   dash_p     out  1  one-cycle pulse: dash accepted
//   char_end_p out  1  one-cycle pulse: character complete
//   word_end_p out  1  one-cycle pulse: word complete
//   err_p      out  1  one-cycle pulse: press exceeded DASH_MAX_CYC; symbol discarded
//   sym_cnt    out  3  symbols in current character (saturates at 7; cleared on char_end_p)
// BEHAVIOUR
//   - Reset: all outputs 0, FSM=IDLE, all counters 0, synchroniser and debounced level 0.
//   - Sync: 2-FF synchroniser on key_in; its output is ks.
//   - Debounce: db_cnt counts while ks != key_level and clears when they are equal.
//     When db_cnt reaches DEBOUNCE_CYC-1 with ks still different, key_level takes ks
//     on the next edge and db_cnt clears. Glitches shorter than DEBOUNCE_CYC are ignored.
//   - dur_cnt clears on the rising edge of key_level and increments each cycle while
//     key_level=1, saturating at 2^CNT_W-1.
//   - gap_cnt clears on the falling edge of key_level and increments each cycle while
//     key_level=0, saturating.
//   - FSM states: IDLE, PRESS, GAP, WGAP.
//     IDLE: key_level rise -> PRESS. No gap pulses are produced in IDLE.
//     PRESS: on key_level fall, classify dur_cnt in the same cycle:
//       * dur_cnt < DOT_MAX_CYC -> dot_p
//       * dur_cnt <= DASH_MAX_CYC -> dash_p
//       * otherwise -> err_p
//       The pulse is asserted the cycle after the fall is seen. Next state is GAP.
//       A valid symbol increments sym_cnt. An err_p leaves sym_cnt unchanged.
//     GAP: key_level rise -> PRESS (same character).
//       When gap_cnt == CHAR_GAP_CYC-1:
//       * sym_cnt != 0 -> char_end_p, clear sym_cnt, go to WGAP
//       * sym_cnt == 0 (only errors were keyed) -> go to IDLE, no pulse
//     WGAP: key_level rise -> PRESS (new character, no word_end_p).
//       gap_cnt == WORD_GAP_CYC-1 -> word_end_p, go to IDLE.
//   - At most one of dot_p, dash_p, err_p, char_end_p, word_end_p is high in any cycle.
//   - char_end_p fires exactly once per character. word_end_p fires exactly once per
//     word and only after a char_end_p. An indefinitely idle key produces no further pulses.
//   - Counter saturation never wraps. A stuck-pressed key yields exactly one err_p, on release.
//   - rst_n low mid-press or mid-gap: immediate return to reset values.
//     No pulse is emitted on reset release.
// TESTING (bench params: CNT_W=8, DEBOUNCE_CYC=4, DOT_MAX_CYC=20, DASH_MAX_CYC=60,
//          CHAR_GAP_CYC=30, WORD_GAP_CYC=70)
//   1. Press 10 cycles, release 200 -> dot_p once, then char_end_p 30 cycles after
//      key_level falls, then word_end_p 70 cycles after the fall; sym_cnt 1 -> 0.
//   2. Press 40, release 10, press 10, release 100 -> dash_p, dot_p, sym_cnt=2,
//      one char_end_p; no char_end_p between the two presses.
//   3. Glitches of 1-3 cycles high on idle key -> key_level stays 0, no pulses.
//      Bouncy 3-cycle toggling before a clean 10-cycle press -> exactly one dot_p.
//   4. Press 300 cycles (saturates dur_cnt) -> err_p once on release, sym_cnt=0,
//      no char_end_p, return to IDLE.
//   5. Dot, release 40, dot, release 100 -> two char_end_p, one word_end_p after the
//      second. Also: 8 dots in one character -> sym_cnt saturates at 7.
//   6. Assert rst_n=0 at dur_cnt=15 and release after 5 cycles with key held ->
//      all outputs 0; after reset, release of the key yields a dot_p only if the
//      debounced press is seen again.

Source files
------------

// File: rtl/morse_key_timer.sv
`default_nettype none
// ============================================================================
// Module      : morse_key_timer
// Description : Key synchroniser/debouncer and press/release duration timer
//               that emits dot, dash, error, end-of-character and end-of-word
//               pulses for the downstream Morse decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module morse_key_timer #(
    parameter int CNT_W        = 24,
    parameter int DEBOUNCE_CYC = 50000,
    parameter int DOT_MAX_CYC  = 2000000,
    parameter int DASH_MAX_CYC = 10000000,
    parameter int CHAR_GAP_CYC = 3000000,
    parameter int WORD_GAP_CYC = 7000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_in,
    output logic       key_level,
    output logic       dot_p,
    output logic       dash_p,
    output logic       char_end_p,
    output logic       word_end_p,
    output logic       err_p,
    output logic [2:0] sym_cnt
);

    localparam logic [CNT_W-1:0] c_cnt_max   = '1;
    localparam logic [CNT_W-1:0] c_db_last   = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] c_dot_max   = CNT_W'(DOT_MAX_CYC);
    localparam logic [CNT_W-1:0] c_dash_max  = CNT_W'(DASH_MAX_CYC);
    localparam logic [CNT_W-1:0] c_char_last = CNT_W'(CHAR_GAP_CYC - 1);
    localparam logic [CNT_W-1:0] c_word_last = CNT_W'(WORD_GAP_CYC - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PRESS = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;
    localparam logic [1:0] S_WGAP  = 2'd3;

    logic             r_sync1;
    logic             r_sync2;
    logic             r_key_level;
    logic [CNT_W-1:0] r_db_cnt;
    logic [CNT_W-1:0] r_dur_cnt;
    logic [CNT_W-1:0] r_gap_cnt;
    logic [1:0]       r_state;
    logic [2:0]       r_sym_cnt;
    logic             r_dot_p;
    logic             r_dash_p;
    logic             r_err_p;
    logic             r_char_end_p;
    logic             r_word_end_p;

    logic w_ks;
    logic w_db_accept;
    logic w_rise_acc;
    logic w_fall_acc;

    assign w_ks        = r_sync2;
    assign w_db_accept = (w_ks != r_key_level) && (r_db_cnt == c_db_last);
    assign w_rise_acc  = w_db_accept && w_ks;
    assign w_fall_acc  = w_db_accept && !w_ks;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= key_in;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key_level <= 1'b0;
            r_db_cnt    <= '0;
        end else if (w_ks == r_key_level) begin
            r_db_cnt <= '0;
        end else if (w_db_accept) begin
            r_key_level <= w_ks;
            r_db_cnt    <= '0;
        end else begin
            r_db_cnt <= r_db_cnt + 1'b1;
        end
    end

    // Both timers restart on the edge that updates key_level, so the first
    // cycle of a new level always reads zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dur_cnt <= '0;
            r_gap_cnt <= '0;
        end else begin
            if (w_rise_acc)
                r_dur_cnt <= '0;
            else if (r_key_level && (r_dur_cnt != c_cnt_max))
                r_dur_cnt <= r_dur_cnt + 1'b1;

            if (w_fall_acc)
                r_gap_cnt <= '0;
            else if (!r_key_level && (r_gap_cnt != c_cnt_max))
                r_gap_cnt <= r_gap_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_sym_cnt    <= 3'd0;
            r_dot_p      <= 1'b0;
            r_dash_p     <= 1'b0;
            r_err_p      <= 1'b0;
            r_char_end_p <= 1'b0;
            r_word_end_p <= 1'b0;
        end else begin
            r_dot_p      <= 1'b0;
            r_dash_p     <= 1'b0;
            r_err_p      <= 1'b0;
            r_char_end_p <= 1'b0;
            r_word_end_p <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (r_key_level)
                        r_state <= S_PRESS;
                end
                S_PRESS: begin
                    if (!r_key_level) begin
                        r_state <= S_GAP;
                        if (r_dur_cnt <= c_dash_max) begin
                            if (r_dur_cnt < c_dot_max)
                                r_dot_p <= 1'b1;
                            else
                                r_dash_p <= 1'b1;
                            if (r_sym_cnt != 3'd7)
                                r_sym_cnt <= r_sym_cnt + 3'd1;
                        end else begin
                            r_err_p <= 1'b1;
                        end
                    end
                end
                S_GAP: begin
                    if (r_key_level) begin
                        r_state <= S_PRESS;
                    end else if (r_gap_cnt == c_char_last) begin
                        // A character made only of rejected presses ends silently.
                        if (r_sym_cnt != 3'd0) begin
                            r_char_end_p <= 1'b1;
                            r_sym_cnt    <= 3'd0;
                            r_state      <= S_WGAP;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_WGAP: begin
                    if (r_key_level) begin
                        r_state <= S_PRESS;
                    end else if (r_gap_cnt == c_word_last) begin
                        r_word_end_p <= 1'b1;
                        r_state      <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign key_level  = r_key_level;
    assign dot_p      = r_dot_p;
    assign dash_p     = r_dash_p;
    assign err_p      = r_err_p;
    assign char_end_p = r_char_end_p;
    assign word_end_p = r_word_end_p;
    assign sym_cnt    = r_sym_cnt;

endmodule
`default_nettype wire

// File: tb/tb_morse_key_timer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_morse_key_timer
// Description : Scoreboard bench for morse_key_timer with small timing params.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_morse_key_timer;

    localparam int CNT_W        = 8;
    localparam int DEBOUNCE_CYC = 4;
    localparam int DOT_MAX_CYC  = 20;
    localparam int DASH_MAX_CYC = 60;
    localparam int CHAR_GAP_CYC = 30;
    localparam int WORD_GAP_CYC = 70;
    // key_in change after edge j -> key_level changes on edge j+6
    localparam int c_lat        = 2 + DEBOUNCE_CYC;

    localparam logic [4:0] K_DOT  = 5'b00001;
    localparam logic [4:0] K_DASH = 5'b00010;
    localparam logic [4:0] K_ERR  = 5'b00100;
    localparam logic [4:0] K_CHAR = 5'b01000;
    localparam logic [4:0] K_WORD = 5'b10000;

    typedef struct {
        logic [4:0] kind;
        int         cyc;
        int         sym;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       key_in;
    logic       key_level;
    logic       dot_p;
    logic       dash_p;
    logic       char_end_p;
    logic       word_end_p;
    logic       err_p;
    logic [2:0] sym_cnt;

    exp_t sb[$];
    int   cyc;
    int   n_checks;
    int   n_pass;
    int   m_sym;

    morse_key_timer #(
        .CNT_W       (CNT_W),
        .DEBOUNCE_CYC(DEBOUNCE_CYC),
        .DOT_MAX_CYC (DOT_MAX_CYC),
        .DASH_MAX_CYC(DASH_MAX_CYC),
        .CHAR_GAP_CYC(CHAR_GAP_CYC),
        .WORD_GAP_CYC(WORD_GAP_CYC)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_in    (key_in),
        .key_level (key_level),
        .dot_p     (dot_p),
        .dash_p    (dash_p),
        .char_end_p(char_end_p),
        .word_end_p(word_end_p),
        .err_p     (err_p),
        .sym_cnt   (sym_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [4:0] kind, input int at, input int sym);
        exp_t e;
        e.kind = kind;
        e.cyc  = at;
        e.sym  = sym;
        sb.push_back(e);
    endtask

    // Key has just been released after edge cyc; key_level was high for hi cycles.
    task automatic predict_release(input int hi, input int lo);
        int j;
        int d;
        j = cyc;
        d = (hi > 255) ? 255 : hi;
        if (d <= DASH_MAX_CYC) begin
            m_sym = (m_sym == 7) ? 7 : m_sym + 1;
            push((d < DOT_MAX_CYC) ? K_DOT : K_DASH, j + c_lat + 1, m_sym);
        end else begin
            push(K_ERR, j + c_lat + 1, m_sym);
        end
        if (lo >= CHAR_GAP_CYC && m_sym != 0) begin
            m_sym = 0;
            push(K_CHAR, j + c_lat + CHAR_GAP_CYC, 0);
            if (lo >= WORD_GAP_CYC)
                push(K_WORD, j + c_lat + WORD_GAP_CYC, 0);
        end else if (lo >= CHAR_GAP_CYC) begin
            m_sym = 0;
        end
    endtask

    task automatic press(input int hi, input int lo);
        key_in = 1'b1;
        step(hi);
        key_in = 1'b0;
        predict_release(hi, lo);
        step(lo);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_level"}, int'(key_level), 0);
        check({tag, "_pulses"}, int'({word_end_p, char_end_p, err_p, dash_p, dot_p}), 0);
        check({tag, "_sym"}, int'(sym_cnt), 0);
    endtask

    always @(negedge clk) begin : mon
        logic [4:0] obs;
        exp_t       e;
        obs = {word_end_p, char_end_p, err_p, dash_p, dot_p};
        if (rst_n && obs != 5'd0) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse", int'(obs), 0);
            end else begin
                e = sb.pop_front();
                check("pulse_kind", int'(obs), int'(e.kind));
                check("pulse_cycle", cyc, e.cyc);
                check("pulse_sym_cnt", int'(sym_cnt), e.sym);
            end
        end
    end

    initial begin
        int seen;
        n_checks = 0;
        n_pass   = 0;
        m_sym    = 0;
        rst_n    = 1'b0;
        key_in   = 1'b0;
        step(3);
        check_quiet("reset");
        rst_n = 1'b1;
        step(5);

        // single dot, full character and word gap
        press(10, 200);
        // dash + dot in one character
        press(40, 10);
        press(10, 100);

        // short glitches never reach key_level
        seen = 0;
        for (int g = 1; g <= 3; g++) begin
            key_in = 1'b1;
            for (int k = 0; k < g; k++) begin
                step(1);
                seen = seen | int'(key_level);
            end
            key_in = 1'b0;
            for (int k = 0; k < 12; k++) begin
                step(1);
                seen = seen | int'(key_level);
            end
        end
        check("glitch_level", seen, 0);

        // bounce then a clean dot
        for (int b = 0; b < 2; b++) begin
            key_in = 1'b1;
            step(3);
            key_in = 1'b0;
            step(3);
        end
        press(10, 100);

        // stuck key: error only, no character end
        press(300, 200);

        // two characters, one word
        press(8, 40);
        press(8, 100);

        // sym_cnt saturation
        for (int i = 0; i < 7; i++)
            press(5, 10);
        press(5, 100);

        // reset mid-press, key held through reset
        key_in = 1'b1;
        step(c_lat + 15);
        rst_n = 1'b0;
        m_sym = 0;
        step(5);
        check_quiet("midpress_reset");
        rst_n = 1'b1;
        step(10);
        key_in = 1'b0;
        predict_release(10, 100);
        step(100);

        for (int t = 0; t < 300 && sb.size() != 0; t++)
            step(1);
        check("scoreboard_drained", sb.size(), 0);
        step(300);
        check_quiet("final_idle");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
